btb_assoc_predictor: RTL
========================

BTB_ASSOC_PREDICTOR -- requirements
Module: btb_assoc_predictor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC width.
REQ-002 SHALL have parameter SETS, default 64, number of sets, power of two, at least 2; IDX_W = $clog2(SETS).
REQ-003 SHALL have parameter WAYS, default 2, associativity, power of two, 1 to 8.
REQ-004 SHALL have parameter CNT_W, default 2, width of the taken/not-taken saturating counter.
REQ-005 SHALL have port cpu_clk, input, 1 bit, the single clock; all state on rising edge.
REQ-006 SHALL have port cpu_rst, input, 1 bit, reset, asynchronous, active-high.
REQ-007 SHALL have port next_pc, input, ADDR_WIDTH bits, fetch address, used for the lookup index.
REQ-008 SHALL have port pc, input, ADDR_WIDTH bits, the address of the fetch one cycle later, used for the tag compare.
REQ-009 SHALL have port predict_hit, output, 1 bit, pc matches a valid entry.
REQ-010 SHALL have port predict_taken, output, 1 bit, hit entry predicts taken.
REQ-011 SHALL have port predict_target_pc, output, ADDR_WIDTH bits, target of the hit way; 0 on miss.
REQ-012 SHALL have port upd_valid, input, 1 bit, a resolved branch from EX.
REQ-013 SHALL have port upd_pc / upd_target, input, ADDR_WIDTH bits each, branch PC and resolved target.
REQ-014 SHALL have port upd_taken, input, 1 bit, resolved direction.
REQ-015 SHALL have port flush_req, input, 1 bit, one-cycle pulse that invalidates all entries.
REQ-016 SHALL have port flush_busy, output, 1 bit, high while a flush sweep runs.

Function
REQ-017 SHALL form index = addr[IDX_W+1:2] and tag = addr[ADDR_WIDTH-1:IDX_W+2], for both lookup and update.
REQ-018 SHALL register the lookup set contents on the cycle next_pc is presented; the compare against pc happens the following cycle, giving 1-cycle latency.
REQ-019 SHALL assert predict_hit when exactly one way is valid with a matching tag; predict_taken = hit AND counter MSB; predict_target_pc = that way's target.
REQ-020 SHALL maintain the invariant that an update hit refreshes the matching way, so duplicate tags within a set never arise.
REQ-021 SHALL apply an update hit as follows: counter +1 if upd_taken, -1 otherwise, saturating at all-ones and at zero; target overwritten only when upd_taken.
REQ-022 SHALL allocate on an update miss with upd_taken=1 as follows: lowest-index invalid way, else the way at the set's round-robin pointer; the pointer then advances modulo WAYS; the new counter = weakly taken (MSB=1, rest 0).
REQ-023 SHALL make no state change on an update miss with upd_taken=0.
REQ-024 SHALL give a lookup and an update to the same set in the same cycle the pre-update contents (read-before-write); an update's effect is visible to the lookup issued one cycle later.
REQ-025 SHALL implement a flush FSM with states IDLE and SWEEP.
REQ-026 SHALL, on flush_req in IDLE, enter SWEEP and clear the valid bits of set 0..SETS-1, one set per cycle, for exactly SETS cycles, then return to IDLE.
REQ-027 SHALL, in SWEEP, hold flush_busy=1, force predict_hit/predict_taken=0 and predict_target_pc=0, and drop updates (not queued).
REQ-028 SHALL ignore flush_req while in SWEEP; flush_req and upd_valid in the same IDLE cycle: flush wins and the update is dropped.
REQ-029 SHALL wrap the sweep counter at SETS-1 to return to IDLE, with no extra idle cycle before the next flush_req is accepted.

Reset
REQ-030 SHALL, on cpu_rst asserted, asynchronously clear all valid bits, round-robin pointers, the lookup register, the sweep counter, and FSM to IDLE; outputs predict_hit=0, predict_taken=0, predict_target_pc=0, flush_busy=0.
REQ-031 SHALL leave tag, target and counter arrays unreset (SRAM-mappable); validity alone gates use.
REQ-032 SHALL, on reset asserted mid-sweep, abort the sweep; after release, the block is in IDLE with all entries invalid.

Structure
REQ-033 SHALL place the counter init/max constants and the FSM state typedef in shared package bp_pkg.
REQ-034 SHALL implement the saturating counter update as sub-module bp_sat_counter (parameter CNT_W).
REQ-035 SHALL keep tag/target storage as per-way arrays with one read port and one write port, replaceable by SRAM macros.

Verification
REQ-036 Lookup after reset: next_pc=0x100, pc=0x100 next cycle -> predict_hit=0, predict_target_pc=0.
REQ-037 Allocate and hit: upd pc=0x100, taken, target 0x200; then lookup 0x100 -> hit=1, taken=1, target=0x200.
REQ-038 Counter saturation: 3 not-taken updates to 0x100 -> counter 0, predict_taken=0 with hit=1; then 5 taken -> counter 3, predict_taken=1.
REQ-039 Replacement (SETS=64, WAYS=2): taken updates to 0x100, 0x200, 0x300 (same set) -> 0x100 evicted, 0x200 and 0x300 hit.
REQ-040 Flush: flush_req pulse -> flush_busy high exactly 64 cycles, update during sweep dropped, all lookups miss afterwards.
REQ-041 Same-cycle update and lookup to 0x100 -> that lookup misses; lookup one cycle later hits.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer predictor.
package bp_pkg;

  // Flush sweep controller states.
  typedef enum logic {
    FLUSH_IDLE  = 1'b0,
    FLUSH_SWEEP = 1'b1
  } flush_state_e;

  // Weakly-taken value for a freshly allocated counter: MSB set, rest clear.
  function automatic int unsigned cnt_init(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Saturation ceiling of a w-bit counter (all ones).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter step used by the predictor's update path.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_q,
  input  logic             up,
  output logic [CNT_W-1:0] cnt_d
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  // Step toward taken or not-taken, holding at either end.
  always_comb begin
    cnt_d = cnt_q;
    if (up) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/btb_assoc_predictor.sv
// Set-associative branch target buffer with 1-cycle lookup, EX-stage update
// and a one-set-per-cycle flush sweep.
//
// Lookup: next_pc selects the set; its ways are registered at the edge and
// compared against pc (the same fetch, one cycle later) combinationally.
// Update: a single-cycle read-modify-write of the set chosen by upd_pc,
// accepted only while the flush controller is idle and no flush starts.
module btb_assoc_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target_pc,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_taken,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

  // Unreset storage; validity alone decides whether an entry is used.
  logic [TAG_W-1:0]      tag_mem [WAYS][SETS];
  logic [ADDR_WIDTH-1:0] tgt_mem [WAYS][SETS];
  logic [CNT_W-1:0]      cnt_mem [WAYS][SETS];

  // Reset state.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];
  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  // Lookup register: the set read at next_pc, compared a cycle later.
  logic [WAYS-1:0]       rd_valid_q;
  logic [TAG_W-1:0]      rd_tag_q [WAYS];
  logic [ADDR_WIDTH-1:0] rd_tgt_q [WAYS];
  logic [WAYS-1:0]       rd_dir_q;

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] pc_tag, u_tag;

  logic             u_hit, u_free;
  logic [WAY_W-1:0] u_hit_way, u_free_way, alloc_way;
  logic [CNT_W-1:0] u_hit_cnt, u_new_cnt;
  logic             upd_ok, do_hit, do_alloc;

  logic [WAYS-1:0]       match;
  logic [ADDR_WIDTH-1:0] hit_tgt;
  logic                  hit_dir;

  logic unused_addr_bits;

  assign lk_idx = next_pc[IDX_W+1:2];
  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign pc_tag = pc[ADDR_WIDTH-1:IDX_W+2];

  // Byte-offset bits and the lookup tag of next_pc play no part.
  assign unused_addr_bits = ^{next_pc[ADDR_WIDTH-1:IDX_W+2], next_pc[1:0],
                              pc[IDX_W+1:0], upd_pc[1:0]};

  // An update is dropped during a sweep and when a flush starts this cycle.
  assign upd_ok   = upd_valid && (state_q == FLUSH_IDLE) && !flush_req;
  assign do_hit   = upd_ok && u_hit;
  assign do_alloc = upd_ok && !u_hit && upd_taken;

  assign flush_busy = (state_q == FLUSH_SWEEP);

  // Find the matching way and the lowest free way in the update set.
  always_comb begin
    u_hit      = 1'b0;
    u_hit_way  = '0;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!u_hit && valid_q[u_idx][w] && (tag_mem[w][u_idx] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_W'(w);
      end
      if (!u_free && !valid_q[u_idx][w]) begin
        u_free     = 1'b1;
        u_free_way = WAY_W'(w);
      end
    end
    u_hit_cnt = cnt_mem[u_hit_way][u_idx];
    alloc_way = u_free ? u_free_way : rr_q[u_idx];
  end

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .cnt_q (u_hit_cnt),
    .up    (upd_taken),
    .cnt_d (u_new_cnt)
  );

  // Write port of the tag/target/counter arrays (no reset, SRAM-mappable).
  always_ff @(posedge cpu_clk) begin
    if (do_hit) begin
      cnt_mem[u_hit_way][u_idx] <= u_new_cnt;
      if (upd_taken) tgt_mem[u_hit_way][u_idx] <= upd_target;
    end else if (do_alloc) begin
      tag_mem[alloc_way][u_idx] <= u_tag;
      tgt_mem[alloc_way][u_idx] <= upd_target;
      cnt_mem[alloc_way][u_idx] <= CNT_INIT;
    end
  end

  // Valid bits and round-robin pointers: set on allocation, cleared by the sweep.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (state_q == FLUSH_SWEEP) valid_q[sweep_q] <= '0;
      if (do_alloc) begin
        valid_q[u_idx][alloc_way] <= 1'b1;
        if (rr_q[u_idx] == WAY_W'(WAYS - 1)) rr_q[u_idx] <= '0;
        else                                 rr_q[u_idx] <= rr_q[u_idx] + 1'b1;
      end
    end
  end

  // Read port: capture the lookup set (pre-update contents); nothing valid during a sweep.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rd_valid_q <= '0;
      rd_dir_q   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_q[w] <= '0;
        rd_tgt_q[w] <= '0;
      end
    end else begin
      rd_valid_q <= (state_q == FLUSH_SWEEP) ? '0 : valid_q[lk_idx];
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_q[w] <= tag_mem[w][lk_idx];
        rd_tgt_q[w] <= tgt_mem[w][lk_idx];
        rd_dir_q[w] <= cnt_mem[w][lk_idx][CNT_W-1];
      end
    end
  end

  // Flush controller state register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= FLUSH_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Flush next state: sweep sets 0..SETS-1 then return to idle with no gap.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      FLUSH_IDLE: begin
        if (flush_req) begin
          state_d = FLUSH_SWEEP;
          sweep_d = '0;
        end
      end
      FLUSH_SWEEP: begin
        if (sweep_q == IDX_W'(SETS - 1)) begin
          state_d = FLUSH_IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: begin
        state_d = FLUSH_IDLE;
        sweep_d = '0;
      end
    endcase
  end

  // Tag compare against pc; a hit needs exactly one matching valid way.
  always_comb begin
    match   = '0;
    hit_tgt = '0;
    hit_dir = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = rd_valid_q[w] && (rd_tag_q[w] == pc_tag);
      if (match[w]) begin
        hit_tgt = hit_tgt | rd_tgt_q[w];
        hit_dir = hit_dir | rd_dir_q[w];
      end
    end
    predict_hit       = $onehot(match) && (state_q == FLUSH_IDLE);
    predict_taken     = predict_hit && hit_dir;
    predict_target_pc = predict_hit ? hit_tgt : '0;
  end

endmodule
